// File: rtl/decrypt_iter_pkg.sv
// rtl/decrypt_iter_pkg.sv - shared cipher parameters, FSM states and round/key-schedule primitives
package decrypt_iter_pkg;

    localparam int N_B = 64;
    localparam int N_K = 80;
    localparam int N_R = 31;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEYEXP,
        ST_DEC,
        ST_FINAL,
        ST_HOLD
    } state_t;

    function automatic logic [3:0] sbox(input logic [3:0] v);
        logic [3:0] s;
        case (v)
            4'h0: s = 4'hC;  4'h1: s = 4'h5;  4'h2: s = 4'h6;  4'h3: s = 4'hB;
            4'h4: s = 4'h9;  4'h5: s = 4'h0;  4'h6: s = 4'hA;  4'h7: s = 4'hD;
            4'h8: s = 4'h3;  4'h9: s = 4'hE;  4'hA: s = 4'hF;  4'hB: s = 4'h8;
            4'hC: s = 4'h4;  4'hD: s = 4'h7;  4'hE: s = 4'h1;  default: s = 4'h2;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] v);
        logic [3:0] s;
        case (v)
            4'h0: s = 4'h5;  4'h1: s = 4'hE;  4'h2: s = 4'hF;  4'h3: s = 4'h8;
            4'h4: s = 4'hC;  4'h5: s = 4'h1;  4'h6: s = 4'h2;  4'h7: s = 4'hD;
            4'h8: s = 4'hB;  4'h9: s = 4'h4;  4'hA: s = 4'h6;  4'hB: s = 4'h3;
            4'hC: s = 4'h0;  4'hD: s = 4'h7;  4'hE: s = 4'h9;  default: s = 4'hA;
        endcase
        return s;
    endfunction

    // Bit i of the state moves to position (16*i) mod 63; the top bit stays put.
    function automatic logic [5:0] perm_idx(input int i);
        return (i == N_B - 1) ? 6'(N_B - 1) : 6'((i * 16) % (N_B - 1));
    endfunction

    function automatic logic [N_B-1:0] p_layer(input logic [N_B-1:0] x);
        logic [N_B-1:0] y;
        y = '0;
        for (int i = 0; i < N_B; i++) y[perm_idx(i)] = x[i];
        return y;
    endfunction

    function automatic logic [N_B-1:0] inv_p_layer(input logic [N_B-1:0] x);
        logic [N_B-1:0] y;
        y = '0;
        for (int i = 0; i < N_B; i++) y[i] = x[perm_idx(i)];
        return y;
    endfunction

    function automatic logic [N_B-1:0] inv_s_layer(input logic [N_B-1:0] x);
        logic [N_B-1:0] y;
        y = '0;
        for (int i = 0; i < N_B / 4; i++) y[4*i +: 4] = inv_sbox(x[4*i +: 4]);
        return y;
    endfunction

    function automatic logic [N_K-1:0] key_schedule(input logic [N_K-1:0] k, input logic [4:0] rc);
        logic [N_K-1:0] t;
        t          = {k[18:0], k[79:19]};
        t[79:76]   = sbox(t[79:76]);
        t[19:15]   = t[19:15] ^ rc;
        return t;
    endfunction

endpackage

// File: rtl/decrypt_iter_if.sv
// rtl/decrypt_iter_if.sv - key/ciphertext in and plaintext out handshake bundle
interface decrypt_iter_if;
    import decrypt_iter_pkg::*;

    logic           in_valid;
    logic           in_ready;
    logic [N_K-1:0] k;
    logic [N_B-1:0] c;
    logic           out_valid;
    logic           out_ready;
    logic [N_B-1:0] m;

    modport master (
        output in_valid, k, c, out_ready,
        input  in_ready, out_valid, m
    );

    modport slave (
        input  in_valid, k, c, out_ready,
        output in_ready, out_valid, m
    );
endinterface

// File: rtl/decrypt_iter_inv_key_schedule.sv
// rtl/decrypt_iter_inv_key_schedule.sv - undoes one key_schedule step for round constant rc_i
module decrypt_iter_inv_key_schedule
    import decrypt_iter_pkg::*;
(
    input  logic [N_K-1:0] key_i,
    input  logic [4:0]     rc_i,
    output logic [N_K-1:0] key_o
);

    logic [N_K-1:0] t;

    // Reverse order of the forward step: counter XOR, S-box, then rotate right by 61.
    always_comb begin
        t        = key_i;
        t[19:15] = t[19:15] ^ rc_i;
        t[79:76] = inv_sbox(t[79:76]);
        key_o    = {t[60:0], t[79:61]};
    end

endmodule

// File: rtl/decrypt_iter.sv
// rtl/decrypt_iter.sv - iterative one-round-per-cycle decryptor with last-key cache
module decrypt_iter
    import decrypt_iter_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    decrypt_iter_if.slave bus
);

    // One spare counter bit lets r hold N_R+1 without wrapping.
    localparam logic [5:0] R_LAST = 6'(N_R);
    localparam logic [5:0] R_END  = 6'(N_R + 1);

    state_t         state_q, state_d;
    logic [5:0]     r_q, r_d;
    logic [N_B-1:0] x_q, x_d;
    logic [N_B-1:0] m_q, m_d;
    logic [N_K-1:0] key_q, key_d;
    logic [N_K-1:0] cache_k_q, cache_k_d;
    logic [N_K-1:0] cache_klast_q, cache_klast_d;
    logic           cache_valid_q, cache_valid_d;

    logic [N_K-1:0] key_fwd;
    logic [N_K-1:0] key_inv;
    logic [4:0]     rc_inv;
    logic [N_B-1:0] rk;
    logic           hit;

    assign rk      = key_q[N_K-1 -: N_B];
    assign key_fwd = key_schedule(key_q, r_q[4:0]);
    assign rc_inv  = 5'(r_q - 6'd1);
    assign hit     = cache_valid_q && (bus.k == cache_k_q);

    decrypt_iter_inv_key_schedule u_inv_ks (
        .key_i (key_q),
        .rc_i  (rc_inv),
        .key_o (key_inv)
    );

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.m         = m_q;

    always_comb begin
        state_d       = state_q;
        r_d           = r_q;
        x_d           = x_q;
        m_d           = m_q;
        key_d         = key_q;
        cache_k_d     = cache_k_q;
        cache_klast_d = cache_klast_q;
        cache_valid_d = cache_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    x_d = bus.c;
                    if (hit) begin
                        key_d   = cache_klast_q;
                        r_d     = R_END;
                        state_d = ST_DEC;
                    end else begin
                        key_d         = bus.k;
                        cache_k_d     = bus.k;
                        cache_valid_d = 1'b0;
                        r_d           = 6'd1;
                        state_d       = ST_KEYEXP;
                    end
                end
            end
            ST_KEYEXP: begin
                key_d = key_fwd;
                r_d   = r_q + 6'd1;
                if (r_q == R_LAST) begin
                    cache_klast_d = key_fwd;
                    cache_valid_d = 1'b1;
                    state_d       = ST_DEC;
                end
            end
            ST_DEC: begin
                x_d   = inv_s_layer(inv_p_layer(x_q ^ rk));
                key_d = key_inv;
                r_d   = r_q - 6'd1;
                if (r_q == 6'd2) state_d = ST_FINAL;
            end
            ST_FINAL: begin
                m_d     = x_q ^ rk;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            r_q           <= '0;
            x_q           <= '0;
            m_q           <= '0;
            key_q         <= '0;
            cache_k_q     <= '0;
            cache_klast_q <= '0;
            cache_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            r_q           <= r_d;
            x_q           <= x_d;
            m_q           <= m_d;
            key_q         <= key_d;
            cache_k_q     <= cache_k_d;
            cache_klast_q <= cache_klast_d;
            cache_valid_q <= cache_valid_d;
        end
    end

endmodule
